// File: rtl/mv_scale_sched.sv
// Round-robin scheduler that shares one MV scale unit between NUM_REQ requesters.
// Latches the granted operands, pulses the unit's start, and returns tagged responses.

module mv_scale_sched #(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned ID_W    = 2,
   parameter int unsigned TIMEOUT = 16,
   localparam int unsigned MV_W   = 15
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ack,
   input  logic [NUM_REQ*MV_W-1:0]   req_poc_diff1,
   input  logic [NUM_REQ*MV_W-1:0]   req_poc_diff2,
   input  logic [NUM_REQ*MV_W-1:0]   req_mv0,
   input  logic [NUM_REQ*MV_W-1:0]   req_mv1,
   output logic                      rsp_valid,
   output logic [ID_W-1:0]           rsp_id,
   output logic [MV_W-1:0]           rsp_mv0,
   output logic [MV_W-1:0]           rsp_mv1,
   output logic                      rsp_err,
   output logic                      busy,
   output logic                      scale_start,
   output logic [MV_W-1:0]           scale_poc_diff1,
   output logic [MV_W-1:0]           scale_poc_diff2,
   output logic [MV_W-1:0]           scale_mv0,
   output logic [MV_W-1:0]           scale_mv1,
   input  logic [MV_W-1:0]           scale_mv0_scaled,
   input  logic [MV_W-1:0]           scale_mv1_scaled,
   input  logic                      scale_done
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_e;

   state_e            state_q, state_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ID_W-1:0]   op_id_q, op_id_d;
   logic [MV_W-1:0]   op_td_q, op_td_d, op_tb_q, op_tb_d;
   logic [MV_W-1:0]   op_mv0_q, op_mv0_d, op_mv1_q, op_mv1_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
   logic [MV_W-1:0]   rsp_mv0_q, rsp_mv0_d, rsp_mv1_q, rsp_mv1_d;
   logic              rsp_err_q, rsp_err_d;

   logic [MV_W-1:0]   td_a  [NUM_REQ];
   logic [MV_W-1:0]   tb_a  [NUM_REQ];
   logic [MV_W-1:0]   mv0_a [NUM_REQ];
   logic [MV_W-1:0]   mv1_a [NUM_REQ];
   logic [PTR_W-1:0]  arb_idx, gnt_idx;
   logic              gnt_vld, bypass, timeout;

   // Unpack the flat per-requester operand buses
   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         td_a[i]  = req_poc_diff1[i*MV_W +: MV_W];
         tb_a[i]  = req_poc_diff2[i*MV_W +: MV_W];
         mv0_a[i] = req_mv0[i*MV_W +: MV_W];
         mv1_a[i] = req_mv1[i*MV_W +: MV_W];
      end
   end

   // First requesting index at or after the pointer, wrapping
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      arb_idx = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         arb_idx = PTR_W'((32'(ptr_q) + k) % NUM_REQ);
         if (!gnt_vld && req_valid[arb_idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = arb_idx;
         end
      end
   end

   assign bypass  = (td_a[gnt_idx] == tb_a[gnt_idx]) || (td_a[gnt_idx] == '0);
   assign timeout = (cnt_q == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin : next_state
      state_d = state_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (gnt_vld) state_d = bypass ? RESP : START;
            START:   state_d = WAIT;
            WAIT:    if (scale_done || timeout) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin : outputs
      req_ack     = '0;
      scale_start = 1'b0;
      busy        = 1'b0;
      rsp_valid   = 1'b0;
      case (state_q)
         IDLE:    if (rst_n && !flush && gnt_vld) req_ack[gnt_idx] = 1'b1;
         START: begin
            scale_start = 1'b1;
            busy        = 1'b1;
         end
         WAIT:    busy = 1'b1;
         RESP: begin
            busy      = 1'b1;
            rsp_valid = !flush;
         end
         default: ;
      endcase
   end

   // Operand latch, pointer, WAIT counter and held response fields
   always_comb begin : datapath
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      op_id_d   = op_id_q;
      op_td_d   = op_td_q;
      op_tb_d   = op_tb_q;
      op_mv0_d  = op_mv0_q;
      op_mv1_d  = op_mv1_q;
      rsp_id_d  = rsp_id_q;
      rsp_mv0_d = rsp_mv0_q;
      rsp_mv1_d = rsp_mv1_q;
      rsp_err_d = rsp_err_q;
      if (flush) begin
         cnt_d = '0;
      end else begin
         case (state_q)
            IDLE: if (gnt_vld) begin
               ptr_d    = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
               op_id_d  = ID_W'(gnt_idx);
               op_td_d  = td_a[gnt_idx];
               op_tb_d  = tb_a[gnt_idx];
               op_mv0_d = mv0_a[gnt_idx];
               op_mv1_d = mv1_a[gnt_idx];
               if (bypass) begin
                  rsp_id_d  = ID_W'(gnt_idx);
                  rsp_mv0_d = mv0_a[gnt_idx];
                  rsp_mv1_d = mv1_a[gnt_idx];
                  rsp_err_d = 1'b0;
               end
            end
            START: cnt_d = '0;
            WAIT: begin
               cnt_d = cnt_q + 1'b1;
               if (scale_done) begin
                  rsp_id_d  = op_id_q;
                  rsp_mv0_d = scale_mv0_scaled;
                  rsp_mv1_d = scale_mv1_scaled;
                  rsp_err_d = 1'b0;
               end else if (timeout) begin
                  rsp_id_d  = op_id_q;
                  rsp_mv0_d = op_mv0_q;
                  rsp_mv1_d = op_mv1_q;
                  rsp_err_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q     <= '0;
         cnt_q     <= '0;
         op_id_q   <= '0;
         op_td_q   <= '0;
         op_tb_q   <= '0;
         op_mv0_q  <= '0;
         op_mv1_q  <= '0;
         rsp_id_q  <= '0;
         rsp_mv0_q <= '0;
         rsp_mv1_q <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         op_id_q   <= op_id_d;
         op_td_q   <= op_td_d;
         op_tb_q   <= op_tb_d;
         op_mv0_q  <= op_mv0_d;
         op_mv1_q  <= op_mv1_d;
         rsp_id_q  <= rsp_id_d;
         rsp_mv0_q <= rsp_mv0_d;
         rsp_mv1_q <= rsp_mv1_d;
         rsp_err_q <= rsp_err_d;
      end
   end

   assign scale_poc_diff1 = op_td_q;
   assign scale_poc_diff2 = op_tb_q;
   assign scale_mv0       = op_mv0_q;
   assign scale_mv1       = op_mv1_q;
   assign rsp_id          = rsp_id_q;
   assign rsp_mv0         = rsp_mv0_q;
   assign rsp_mv1         = rsp_mv1_q;
   assign rsp_err         = rsp_err_q;

endmodule

// File: tb/tb_mv_scale_sched.sv
// Bench for mv_scale_sched: transaction-timing reference model plus a behavioural scale unit.
// Expected grants, response cycles and values come from the model's own schedule.

module tb_mv_scale_sched;

   localparam int unsigned NUM_REQ = 3;
   localparam int unsigned ID_W    = 2;
   localparam int unsigned TIMEOUT = 16;
   localparam int unsigned W       = 15;
   localparam int          NREQ    = int'(NUM_REQ);

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b1;
   logic                   flush = 1'b0;
   logic [NUM_REQ-1:0]     req_valid, req_ack;
   logic [NUM_REQ*W-1:0]   req_poc_diff1, req_poc_diff2, req_mv0, req_mv1;
   logic                   rsp_valid, rsp_err, busy, scale_start, scale_done;
   logic [ID_W-1:0]        rsp_id;
   logic [W-1:0]           rsp_mv0, rsp_mv1;
   logic [W-1:0]           scale_poc_diff1, scale_poc_diff2, scale_mv0, scale_mv1;
   logic [W-1:0]           scale_mv0_scaled, scale_mv1_scaled;

   always #5 clk = ~clk;

   mv_scale_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .req_valid(req_valid), .req_ack(req_ack),
      .req_poc_diff1(req_poc_diff1), .req_poc_diff2(req_poc_diff2),
      .req_mv0(req_mv0), .req_mv1(req_mv1),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_mv0(rsp_mv0), .rsp_mv1(rsp_mv1),
      .rsp_err(rsp_err), .busy(busy), .scale_start(scale_start),
      .scale_poc_diff1(scale_poc_diff1), .scale_poc_diff2(scale_poc_diff2),
      .scale_mv0(scale_mv0), .scale_mv1(scale_mv1),
      .scale_mv0_scaled(scale_mv0_scaled), .scale_mv1_scaled(scale_mv1_scaled),
      .scale_done(scale_done)
   );

   // Behavioural scale unit: mv*tb/td, done 9 cycles after its start pulse, held until the next one
   function automatic logic [W-1:0] scale_fn(input logic [W-1:0] mv, input logic [W-1:0] td,
                                             input logic [W-1:0] tb);
      int m, d, b;
      m = int'($signed(mv));
      d = int'($signed(td));
      b = int'($signed(tb));
      if (d == 0) return '0;
      return W'((m * b) / d);
   endfunction

   logic [3:0] sm_cnt = '0;
   logic       sm_run = 1'b0;
   bit         no_done = 1'b0;

   always @(posedge clk) begin
      if (scale_start) begin
         sm_cnt <= '0;
         sm_run <= 1'b1;
      end else if (sm_run && sm_cnt != 4'd15) begin
         sm_cnt <= sm_cnt + 4'd1;
      end
   end

   assign scale_done       = sm_run && !no_done && (sm_cnt >= 4'd8);
   assign scale_mv0_scaled = scale_fn(scale_mv0, scale_poc_diff1, scale_poc_diff2);
   assign scale_mv1_scaled = scale_fn(scale_mv1, scale_poc_diff1, scale_poc_diff2);

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   bit           m_act = 1'b0, m_byp = 1'b0, rearm = 1'b0;
   int           m_start = -1, m_resp = -1, m_ptr = 0, m_id = 0;
   logic [W-1:0] m_td, m_tb, m_mv0, m_mv1, e_mv0, e_mv1;
   bit           e_err;
   int           h_id = 0;
   logic [W-1:0] h_mv0 = '0, h_mv1 = '0;
   bit           h_err = 1'b0;
   bit [NUM_REQ-1:0] pend = '0;
   logic [W-1:0] p_td [NUM_REQ];
   logic [W-1:0] p_tb [NUM_REQ];
   logic [W-1:0] p_m0 [NUM_REQ];
   logic [W-1:0] p_m1 [NUM_REQ];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic drive();
      req_valid = pend;
      for (int i = 0; i < NREQ; i++) begin
         req_poc_diff1[i*W +: W] = p_td[i];
         req_poc_diff2[i*W +: W] = p_tb[i];
         req_mv0[i*W +: W]       = p_m0[i];
         req_mv1[i*W +: W]       = p_m1[i];
      end
   endtask

   task automatic load_req(input int i, input int td, input int tb, input int m0, input int m1);
      p_td[i] = W'(td);
      p_tb[i] = W'(tb);
      p_m0[i] = W'(m0);
      p_m1[i] = W'(m1);
      pend[i] = 1'b1;
   endtask

   task automatic set_req(input int i, input int td, input int tb, input int m0, input int m1);
      load_req(i, td, tb, m0, m1);
      drive();
   endtask

   task automatic rand_load(input int i, input bit scaled_only);
      int td, tb, sel;
      td  = int'($urandom_range(1, 8)) * (($urandom_range(0, 1) == 0) ? -1 : 1);
      tb  = td - int'($urandom_range(1, 3));
      sel = int'($urandom_range(0, 3));
      if (!scaled_only && sel == 0) td = 0;
      if (!scaled_only && sel == 1) tb = td;
      load_req(i, td, tb, int'($urandom_range(0, 2000)) - 1000, int'($urandom_range(0, 2000)) - 1000);
   endtask

   // One clock: compare DUT against the model mid-cycle, advance the model, drive next inputs
   task automatic tick();
      int g;
      logic [NUM_REQ-1:0] e_ack;
      bit e_rsp, e_start, e_busy;
      @(negedge clk);
      g       = -1;
      e_ack   = '0;
      e_start = m_act && !m_byp && (cyc == m_start);
      e_busy  = m_act;
      e_rsp   = 1'b0;
      if (m_act && cyc == m_resp) begin
         h_id  = m_id;
         h_mv0 = e_mv0;
         h_mv1 = e_mv1;
         h_err = e_err;
         e_rsp = !flush;
      end
      if (!m_act && !flush) begin
         for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (g < 0 && pend[idx]) g = idx;
         end
      end
      if (g >= 0) e_ack[g] = 1'b1;

      check("req_ack", 32'(req_ack), 32'(e_ack));
      check("scale_start", 32'(scale_start), 32'(e_start));
      check("busy", 32'(busy), 32'(e_busy));
      check("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
      check("rsp_id", 32'(rsp_id), 32'(h_id));
      check("rsp_mv0", 32'(rsp_mv0), 32'(h_mv0));
      check("rsp_mv1", 32'(rsp_mv1), 32'(h_mv1));
      check("rsp_err", 32'(rsp_err), 32'(h_err));
      if (m_act && !m_byp && cyc >= m_start) begin
         check("scale_poc_diff1", 32'(scale_poc_diff1), 32'(m_td));
         check("scale_poc_diff2", 32'(scale_poc_diff2), 32'(m_tb));
         check("scale_mv0", 32'(scale_mv0), 32'(m_mv0));
         check("scale_mv1", 32'(scale_mv1), 32'(m_mv1));
      end

      if (flush || (m_act && cyc == m_resp)) m_act = 1'b0;
      if (g >= 0) begin
         m_act   = 1'b1;
         m_id    = g;
         m_ptr   = (g + 1) % NREQ;
         m_td    = p_td[g];
         m_tb    = p_tb[g];
         m_mv0   = p_m0[g];
         m_mv1   = p_m1[g];
         pend[g] = 1'b0;
         m_byp   = (m_td == m_tb) || (m_td == '0);
         if (m_byp) begin
            m_resp = cyc + 1;
            e_mv0  = m_mv0;
            e_mv1  = m_mv1;
            e_err  = 1'b0;
         end else begin
            m_start = cyc + 1;
            if (no_done) begin
               m_resp = cyc + 2 + int'(TIMEOUT);
               e_mv0  = m_mv0;
               e_mv1  = m_mv1;
               e_err  = 1'b1;
            end else begin
               m_resp = cyc + 11;
               e_mv0  = scale_fn(m_mv0, m_td, m_tb);
               e_mv1  = scale_fn(m_mv1, m_td, m_tb);
               e_err  = 1'b0;
            end
         end
         if (rearm) rand_load(g, 1'b1);
      end
      cyc++;
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic reset_check();
      check("rst_req_ack", 32'(req_ack), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_scale_start", 32'(scale_start), 32'd0);
      check("rst_rsp_id", 32'(rsp_id), 32'd0);
      check("rst_rsp_mv0", 32'(rsp_mv0), 32'd0);
      check("rst_rsp_mv1", 32'(rsp_mv1), 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      check("rst_scale_td", 32'(scale_poc_diff1), 32'd0);
      check("rst_scale_tb", 32'(scale_poc_diff2), 32'd0);
      check("rst_scale_mv0", 32'(scale_mv0), 32'd0);
      check("rst_scale_mv1", 32'(scale_mv1), 32'd0);
   endtask

   task automatic model_reset();
      m_act = 1'b0;
      m_ptr = 0;
      h_id  = 0;
      h_mv0 = '0;
      h_mv1 = '0;
      h_err = 1'b0;
      pend  = '0;
   endtask

   initial begin
      for (int i = 0; i < NREQ; i++) begin
         p_td[i] = '0; p_tb[i] = '0; p_m0[i] = '0; p_m1[i] = '0;
      end
      drive();
      #1 rst_n = 1'b0;
      #2 reset_check();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(2);

      // Single scaled op, then two bypass flavours
      set_req(0, 2, 1, 100, -100);
      idle(14);
      set_req(1, 5, 5, -37, 12);
      idle(3);
      set_req(1, 0, 9, -37, 12);
      idle(3);

      // All requesters held asserted with scaled ops
      for (int i = 0; i < NREQ; i++) rand_load(i, 1'b1);
      drive();
      rearm = 1'b1;
      idle(60);
      rearm = 1'b0;
      idle(40);

      // Scale unit never finishes
      no_done = 1'b1;
      set_req(2, 3, 1, 7, -3);
      idle(int'(TIMEOUT) + 6);
      no_done = 1'b0;

      // Flush in the 4th WAIT cycle with req2 pending
      set_req(0, 4, 2, 300, -200);
      tick();
      set_req(2, 6, 3, -90, 45);
      idle(4);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      idle(16);

      // Asynchronous reset in the middle of WAIT
      set_req(0, 2, 1, 100, -100);
      idle(5);
      rst_n = 1'b0;
      #1 reset_check();
      model_reset();
      drive();
      @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      set_req(1, 8, 3, 64, -64);
      set_req(0, 2, 1, 100, -100);
      idle(30);

      // Random traffic with occasional drops and flushes
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && $urandom_range(0, 3) == 0) rand_load(i, 1'b0);
            else if (pend[i] && $urandom_range(0, 40) == 0) pend[i] = 1'b0;
         end
         flush = ($urandom_range(0, 49) == 0);
         drive();
         tick();
      end
      flush = 1'b0;
      idle(45);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
